// File: rtl/ual_arbiter.sv
// ual_arbiter: shares one ADD/SUB/AND unit between NREQ requesters.
// Requests are arbitrated round-robin. Each result is registered, tagged with
// the ID of the requester that won, and held until the consumer takes it.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both 1. A result transfers on a rising edge where
// resp_valid and resp_ready are both 1. A requester keeps its operands and
// opcode stable while its req_valid is 1. req_ready may depend
// combinationally on req_valid and resp_ready.
module ual_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_v1,
  input  logic [NREQ*32-1:0]   req_v2,
  input  logic [NREQ*8-1:0]    req_op,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  output logic [31:0]          op_count
);

  // Opcode encodings understood by the shared unit.
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;

  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [31:0]     op_count_q, op_count_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            slot_free;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [31:0]     ual_a, ual_b, ual_out;
  logic [7:0]      ual_op;

  // The output register can take a new result if it is empty or being drained.
  assign slot_free = !resp_valid_q || resp_ready;

  // Round-robin search from the pointer upward, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (slot_free) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!grant_any && req_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = IDW'(idx);
        end
      end
    end
  end

  assign req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;

  // Route the winner's operands to the unit; drive zeros when idle.
  always_comb begin
    ual_a  = 32'h0;
    ual_b  = 32'h0;
    ual_op = 8'h00;
    if (grant_any) begin
      ual_a  = req_v1[32*int'(grant_idx) +: 32];
      ual_b  = req_v2[32*int'(grant_idx) +: 32];
      ual_op = req_op[8*int'(grant_idx) +: 8];
    end
  end

  // Shared unit: modular add/sub, bitwise and; anything else yields zero.
  always_comb begin
    ual_out = 32'h0;
    case (ual_op)
      OP_ADD:  ual_out = ual_a + ual_b;
      OP_SUB:  ual_out = ual_a - ual_b;
      OP_AND:  ual_out = ual_a & ual_b;
      default: ual_out = 32'h0;
    endcase
  end

  // Next state: a grant loads the register (even while draining, no bubble);
  // a drain without a grant empties it; otherwise everything holds.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    op_count_d   = op_count_q;
    ptr_d        = ptr_q;
    if (grant_any) begin
      resp_valid_d = 1'b1;
      resp_id_d    = grant_idx;
      resp_data_d  = ual_out;
      op_count_d   = op_count_q + 32'd1;
      ptr_d        = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State register; reset discards any pending result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= 32'h0;
      op_count_q   <= 32'h0;
      ptr_q        <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      op_count_q   <= op_count_d;
      ptr_q        <= ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_ual_arbiter.sv
// Directed bench for ual_arbiter with two requesters.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered outputs) or 1ns after an input change (combinational grant).
module tb_ual_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;

  logic               clk;
  logic               reset_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_v1;
  logic [NREQ*32-1:0] req_v2;
  logic [NREQ*8-1:0]  req_op;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;
  logic [31:0]        op_count;

  int checks = 0;
  int errors = 0;

  ual_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_v1     (req_v1),
    .req_v2     (req_v2),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .op_count   (op_count)
  );

  // Clock: 10ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    req_v1[32*i +: 32] = a;
    req_v2[32*i +: 32] = b;
    req_op[8*i +: 8]   = op;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic [IDW-1:0] id,
                            input logic [31:0] data, input logic [31:0] cnt);
    check({tag, "_valid"}, {31'b0, resp_valid}, {31'b0, v});
    check({tag, "_id"},    {31'b0, resp_id},    {31'b0, id});
    check({tag, "_data"},  resp_data,           data);
    check({tag, "_count"}, op_count,            cnt);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_v1     = '0;
    req_v2     = '0;
    req_op     = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check_resp("reset", 1'b0, 1'b0, 32'h0, 32'h0);
    check("reset_ready", {30'b0, req_ready}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single request: 0xFFFFFFFF + 2 wraps to 1.
    set_req(0, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002);
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    #1 check("single_ready", {30'b0, req_ready}, 32'h1);
    @(negedge clk);
    check_resp("single", 1'b1, 1'b0, 32'h0000_0001, 32'd1);
    req_valid = 2'b00;

    // Consume with no new grant: valid drops, id/data hold.
    @(negedge clk);
    check_resp("consume", 1'b0, 1'b0, 32'h0000_0001, 32'd1);

    // Unsupported opcode from requester 1 (pointer is at 1).
    set_req(1, 8'hFF, 32'd3, 32'd4);
    req_valid = 2'b10;
    #1 check("badop_ready", {30'b0, req_ready}, 32'h2);
    @(negedge clk);
    check_resp("badop", 1'b1, 1'b1, 32'h0, 32'd2);

    // Round-robin: both valid, pointer back at 0.
    set_req(0, OP_SUB, 32'd5, 32'd7);
    set_req(1, OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    req_valid = 2'b11;
    #1 check("rr0_ready", {30'b0, req_ready}, 32'h1);
    @(negedge clk);
    check_resp("rr0", 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    check("rr1_ready", {30'b0, req_ready}, 32'h2);
    @(negedge clk);
    check_resp("rr1", 1'b1, 1'b1, 32'h00F0_00F0, 32'd4);
    check("rr2_ready", {30'b0, req_ready}, 32'h1);
    @(negedge clk);
    check_resp("rr2", 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd5);
    check("rr3_ready", {30'b0, req_ready}, 32'h2);
    @(negedge clk);
    check_resp("rr3", 1'b1, 1'b1, 32'h00F0_00F0, 32'd6);

    // Back-pressure: result held, req1 waiting with a new operation.
    set_req(1, OP_ADD, 32'd10, 32'd3);
    req_valid  = 2'b10;
    resp_ready = 1'b0;
    #1 check("bp_ready_now", {30'b0, req_ready}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_resp("bp_hold", 1'b1, 1'b1, 32'h00F0_00F0, 32'd6);
      check("bp_ready", {30'b0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    #1 check("bp_release_ready", {30'b0, req_ready}, 32'h2);
    @(negedge clk);
    check_resp("bp_after", 1'b1, 1'b1, 32'h0000_000D, 32'd7);

    // Load a pending result of 5 (consume and grant in the same cycle).
    set_req(0, OP_ADD, 32'd2, 32'd3);
    req_valid = 2'b01;
    @(negedge clk);
    check_resp("pend", 1'b1, 1'b0, 32'h0000_0005, 32'd8);
    req_valid  = 2'b00;
    resp_ready = 1'b0;

    // Asynchronous reset mid-cycle clears the pending result at once.
    #2 reset_n = 1'b0;
    #1 check_resp("async_rst", 1'b0, 1'b0, 32'h0, 32'h0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'b0, resp_valid}, 32'h0);
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    #1 check("post_rst_ready", {30'b0, req_ready}, 32'h1);
    @(negedge clk);
    check_resp("post_rst", 1'b1, 1'b0, 32'h0000_0005, 32'd1);
    req_valid = 2'b00;
    @(negedge clk);

    // Counter wrap: preset the counter to all-ones, issue one operation.
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1 release dut.op_count_q;
    set_req(1, OP_SUB, 32'd9, 32'd4);
    req_valid = 2'b10;
    @(negedge clk);
    check_resp("wrap", 1'b1, 1'b1, 32'h0000_0005, 32'h0);
    req_valid = 2'b00;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
